// File: rtl/mem_write_checker_if.sv
// Signal bundle between a data-memory write checker and whatever drives or observes it.
// The master side owns the monitored bus, table load and start; the slave side owns status.
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;

    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_count;
    logic              start;

    logic              busy;
    logic              done;
    logic              pass;
    logic [1:0]        fail_code;
    logic [CNT_W-1:0]  match_cnt;
    logic [7:0]        stray_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    modport master (
        output mem_write, data_adr, write_data,
        output exp_we, exp_idx, exp_addr, exp_data, exp_count, start,
        input  busy, done, pass, fail_code, match_cnt, stray_cnt, fail_addr, fail_data
    );

    modport slave (
        input  mem_write, data_adr, write_data,
        input  exp_we, exp_idx, exp_addr, exp_data, exp_count, start,
        output busy, done, pass, fail_code, match_cnt, stray_cnt, fail_addr, fail_data
    );
endinterface

// File: rtl/mem_write_checker.sv
// Bus monitor that checks the processor's data-memory writes against an ordered table
// of expected (address, data) pairs, with strict/lenient mode, watchdog and diagnostics.
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096,
    parameter int STRICT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_write_checker_if.slave bus
);
    localparam int  IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int  CNT_W       = $clog2(DEPTH + 1);
    localparam int  WD_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  STRICT_MODE = (STRICT != 0);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CODE_BADCOUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] tbl_addr [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  match_q;
    logic [7:0]        stray_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        code_q;
    logic [ADDR_W-1:0] fadr_q;
    logic [DATA_W-1:0] fdat_q;

    logic              running;
    logic              start_ok;
    logic              load_ok;
    logic              count_bad;
    logic [IDX_W-1:0]  cur_idx;
    logic              hit;
    logic              miss;
    logic              last_hit;
    logic              expired;

    // The entry under test is always the next unmatched one, so match_q doubles as the index.
    assign running   = (state_q == ST_RUN);
    assign start_ok  = bus.start && !running;
    assign load_ok   = bus.exp_we && !running && (int'(bus.exp_idx) < DEPTH);
    assign count_bad = int'(bus.exp_count) > DEPTH;
    assign cur_idx   = IDX_W'(match_q);
    assign hit       = bus.mem_write
                     && (bus.data_adr   == tbl_addr[cur_idx])
                     && (bus.write_data == tbl_data[cur_idx]);
    assign miss      = bus.mem_write && !hit;
    assign last_hit  = hit && ((match_q + 1'b1) == count_q);
    assign expired   = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A match beats both a strict mismatch and the watchdog on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (bus.start) begin
                    if (bus.exp_count == '0) begin
                        state_d = ST_PASS;
                    end else if (count_bad) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (hit) begin
                    if (last_hit) begin
                        state_d = ST_PASS;
                    end
                end else if (miss && STRICT_MODE) begin
                    state_d = ST_FAIL;
                end else if (expired) begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.pass = 1'b0;
        case (state_q)
            ST_RUN:  bus.busy = 1'b1;
            ST_PASS: begin
                bus.done = 1'b1;
                bus.pass = 1'b1;
            end
            ST_FAIL: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Table storage; loads are locked out while a check is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (load_ok) begin
            tbl_addr[bus.exp_idx] <= bus.exp_addr;
            tbl_data[bus.exp_idx] <= bus.exp_data;
        end
    end

    // Counters and diagnostics; the watchdog only ever clears on a match or a new start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            match_q <= '0;
            stray_q <= '0;
            wd_q    <= '0;
            code_q  <= CODE_NONE;
            fadr_q  <= '0;
            fdat_q  <= '0;
        end else if (start_ok) begin
            count_q <= bus.exp_count;
            match_q <= '0;
            stray_q <= '0;
            wd_q    <= '0;
            fadr_q  <= '0;
            fdat_q  <= '0;
            code_q  <= (count_bad && (bus.exp_count != '0)) ? CODE_BADCOUNT : CODE_NONE;
        end else if (running) begin
            if (hit) begin
                match_q <= match_q + 1'b1;
                wd_q    <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
                if (miss && STRICT_MODE) begin
                    code_q <= CODE_MISMATCH;
                    fadr_q <= bus.data_adr;
                    fdat_q <= bus.write_data;
                end else begin
                    if (miss && (stray_q != 8'hFF)) begin
                        stray_q <= stray_q + 8'd1;
                    end
                    if (expired) begin
                        code_q <= CODE_TIMEOUT;
                    end
                end
            end
        end
    end

    assign bus.fail_code = code_q;
    assign bus.match_cnt = match_q;
    assign bus.stray_cnt = stray_q;
    assign bus.fail_addr = fadr_q;
    assign bus.fail_data = fdat_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a strict and a lenient instance watch the same bus
// and are compared against hand-computed expectations.
module tb_mem_write_checker;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) ifs ();
    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) ifl ();

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(16), .STRICT(1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs.slave)
    );

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(16), .STRICT(0)
    ) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (ifl.slave)
    );

    // Both checkers see identical stimulus.
    assign ifl.mem_write  = ifs.mem_write;
    assign ifl.data_adr   = ifs.data_adr;
    assign ifl.write_data = ifs.write_data;
    assign ifl.exp_we     = ifs.exp_we;
    assign ifl.exp_idx    = ifs.exp_idx;
    assign ifl.exp_addr   = ifs.exp_addr;
    assign ifl.exp_data   = ifs.exp_data;
    assign ifl.exp_count  = ifs.exp_count;
    assign ifl.start      = ifs.start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge and each task returns on the next falling edge,
    // so outputs sampled afterwards reflect the rising edge that consumed the inputs.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        ifs.mem_write  = we;
        ifs.data_adr   = adr;
        ifs.write_data = dat;
        @(negedge clk);
        ifs.mem_write  = 1'b0;
        ifs.data_adr   = '0;
        ifs.write_data = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0);
    endtask

    task automatic loadEntry(input int idx, input logic [31:0] adr, input logic [31:0] dat);
        ifs.exp_we   = 1'b1;
        ifs.exp_idx  = 2'(idx);
        ifs.exp_addr = adr;
        ifs.exp_data = dat;
        @(negedge clk);
        ifs.exp_we   = 1'b0;
    endtask

    task automatic startCheck(input int cnt);
        ifs.exp_count = 3'(cnt);
        ifs.start     = 1'b1;
        @(negedge clk);
        ifs.start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got=expired expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        ifs.mem_write = 1'b0; ifs.data_adr = '0; ifs.write_data = '0;
        ifs.exp_we = 1'b0; ifs.exp_idx = '0; ifs.exp_addr = '0; ifs.exp_data = '0;
        ifs.exp_count = '0; ifs.start = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_busy",  32'(ifs.busy), 32'd0);
        checkOutput("rst_done",  32'(ifs.done), 32'd0);
        checkOutput("rst_pass",  32'(ifs.pass), 32'd0);
        checkOutput("rst_code",  32'(ifs.fail_code), 32'd0);
        checkOutput("rst_match", 32'(ifs.match_cnt), 32'd0);
        checkOutput("rst_fadr",  ifs.fail_addr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single write that matches after a few idle cycles.
        loadEntry(0, 32'd252, 32'h0000_1000);
        startCheck(1);
        checkOutput("t1_busy", 32'(ifs.busy), 32'd1);
        idleCycles(3);
        applyStimulus(1'b1, 32'd252, 32'h0000_1000);
        checkOutput("t1_done",  32'(ifs.done), 32'd1);
        checkOutput("t1_pass",  32'(ifs.pass), 32'd1);
        checkOutput("t1_match", 32'(ifs.match_cnt), 32'd1);
        checkOutput("t1_code",  32'(ifs.fail_code), 32'd0);
        checkOutput("t1_l_pass", 32'(ifl.pass), 32'd1);

        // Wrong data: strict fails with diagnostics, lenient counts a stray.
        startCheck(1);
        checkOutput("t2_match_clr", 32'(ifs.match_cnt), 32'd0);
        applyStimulus(1'b1, 32'd252, 32'h0000_0FFF);
        checkOutput("t2_done", 32'(ifs.done), 32'd1);
        checkOutput("t2_pass", 32'(ifs.pass), 32'd0);
        checkOutput("t2_code", 32'(ifs.fail_code), 32'd1);
        checkOutput("t2_fadr", ifs.fail_addr, 32'd252);
        checkOutput("t2_fdat", ifs.fail_data, 32'h0000_0FFF);
        checkOutput("t2_l_busy",  32'(ifl.busy), 32'd1);
        checkOutput("t2_l_stray", 32'(ifl.stray_cnt), 32'd1);
        applyStimulus(1'b1, 32'd252, 32'h0000_1000);
        checkOutput("t2_l_pass",    32'(ifl.pass), 32'd1);
        checkOutput("t2_sticky",    32'(ifs.fail_code), 32'd1);
        checkOutput("t2_sticky_fd", ifs.fail_data, 32'h0000_0FFF);

        // Four-entry sequence with one stray write in the middle.
        loadEntry(0, 32'h10, 32'd1);
        loadEntry(1, 32'h14, 32'd2);
        loadEntry(2, 32'h18, 32'd3);
        loadEntry(3, 32'hFC, 32'h1000);
        startCheck(4);
        applyStimulus(1'b1, 32'h10, 32'd1);
        checkOutput("t3_l_match1", 32'(ifl.match_cnt), 32'd1);
        applyStimulus(1'b1, 32'h40, 32'd7);
        checkOutput("t3_s_code", 32'(ifs.fail_code), 32'd1);
        checkOutput("t3_s_fadr", ifs.fail_addr, 32'h40);
        checkOutput("t3_s_fdat", ifs.fail_data, 32'd7);
        checkOutput("t3_l_stray", 32'(ifl.stray_cnt), 32'd1);
        applyStimulus(1'b1, 32'h14, 32'd2);
        applyStimulus(1'b1, 32'h18, 32'd3);
        checkOutput("t3_l_match3", 32'(ifl.match_cnt), 32'd3);
        checkOutput("t3_l_busy",   32'(ifl.busy), 32'd1);
        applyStimulus(1'b1, 32'hFC, 32'h1000);
        checkOutput("t3_l_pass",   32'(ifl.pass), 32'd1);
        checkOutput("t3_l_match4", 32'(ifl.match_cnt), 32'd4);
        checkOutput("t3_l_stray2", 32'(ifl.stray_cnt), 32'd1);
        checkOutput("t3_s_match",  32'(ifs.match_cnt), 32'd1);

        // Watchdog expiry 16 edges after entering RUN.
        startCheck(1);
        idleCycles(15);
        checkOutput("t4_busy_15", 32'(ifs.busy), 32'd1);
        idleCycles(1);
        checkOutput("t4_done", 32'(ifs.done), 32'd1);
        checkOutput("t4_pass", 32'(ifs.pass), 32'd0);
        checkOutput("t4_code", 32'(ifs.fail_code), 32'd2);
        checkOutput("t4_fadr", ifs.fail_addr, 32'd0);
        checkOutput("t4_fdat", ifs.fail_data, 32'd0);
        checkOutput("t4_l_code", 32'(ifl.fail_code), 32'd2);

        // Match on the expiry edge wins.
        startCheck(1);
        idleCycles(15);
        applyStimulus(1'b1, 32'h10, 32'd1);
        checkOutput("t5_pass", 32'(ifs.pass), 32'd1);
        checkOutput("t5_code", 32'(ifs.fail_code), 32'd0);
        checkOutput("t5_l_pass", 32'(ifl.pass), 32'd1);

        // Count boundaries.
        startCheck(0);
        checkOutput("t6_pass",  32'(ifs.pass), 32'd1);
        checkOutput("t6_busy",  32'(ifs.busy), 32'd0);
        checkOutput("t6_match", 32'(ifs.match_cnt), 32'd0);
        startCheck(5);
        checkOutput("t7_done", 32'(ifs.done), 32'd1);
        checkOutput("t7_pass", 32'(ifs.pass), 32'd0);
        checkOutput("t7_code", 32'(ifs.fail_code), 32'd3);

        // Asynchronous reset in the middle of a running check.
        startCheck(4);
        applyStimulus(1'b1, 32'h10, 32'd1);
        checkOutput("t8_match1", 32'(ifs.match_cnt), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t8_rst_busy",  32'(ifs.busy), 32'd0);
        checkOutput("t8_rst_match", 32'(ifs.match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table was cleared, so entry0 is now (0, 0).
        startCheck(1);
        applyStimulus(1'b1, 32'h0, 32'h0);
        checkOutput("t8_clr_pass", 32'(ifs.pass), 32'd1);
        checkOutput("t8_clr_l",    32'(ifl.pass), 32'd1);

        // Reload, then a load attempted during RUN must be ignored.
        loadEntry(0, 32'h10, 32'd1);
        loadEntry(1, 32'h14, 32'd2);
        startCheck(2);
        loadEntry(1, 32'h99, 32'd9);
        applyStimulus(1'b1, 32'h10, 32'd1);
        checkOutput("t9_match1", 32'(ifs.match_cnt), 32'd1);
        applyStimulus(1'b1, 32'h14, 32'd2);
        checkOutput("t9_pass",  32'(ifs.pass), 32'd1);
        checkOutput("t9_match", 32'(ifs.match_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable bus monitor that watches the processor's data-memory write strobe and checks it against a programmable table of expected (address, data) writes. It generalises the single-write pass/fail check to an ordered sequence of up to DEPTH writes. It adds a strict/lenient mode, a watchdog timeout and captured failure diagnostics. It sits beside the processor top, on the MemWrite/DataAdr/WriteData signals, and drives status to a bench or to a debug register.

Parameters:
ADDR_W, 32, width of the monitored address bus
DATA_W, 32, width of the monitored write-data bus
DEPTH, 4, number of expected-write table entries (>=1)
TIMEOUT, 4096, max cycles in RUN without a matching write before failing (>=1)
STRICT, 1, 1: any non-matching write fails; 0: non-matching writes are counted and ignored

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
mem_write  in  1  monitored write strobe, sampled each rising edge
data_adr  in  ADDR_W  monitored write address
write_data  in  DATA_W  monitored write data
exp_we  in  1  table load strobe (honoured only in IDLE/PASS/FAIL)
exp_idx  in  $clog2(DEPTH)  table entry to load
exp_addr  in  ADDR_W  expected address for entry
exp_data  in  DATA_W  expected data for entry
exp_count  in  $clog2(DEPTH+1)  number of valid entries, latched on start
start  in  1  single-cycle pulse: begin checking
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 bad count (exp_count>DEPTH)
match_cnt  out  $clog2(DEPTH+1)  entries matched so far
stray_cnt  out  8  non-matching writes ignored (STRICT=0), saturates at 255
fail_addr  out  ADDR_W  data_adr of the failing write (0 on timeout)
fail_data  out  DATA_W  write_data of the failing write (0 on timeout)

Behaviour:
- Reset (reset=0): state IDLE; all outputs 0; table contents cleared to 0; watchdog 0.
- FSM states IDLE, RUN, PASS, FAIL. Status outputs are registered and reflect the state one cycle after the causing edge.
- Table load: on an edge with exp_we=1 and state != RUN, entry[exp_idx] <= {exp_addr, exp_data}. exp_we in RUN is ignored.
- start in IDLE/PASS/FAIL: latch exp_count; clear match_cnt, stray_cnt, fail_*, and the watchdog.
  - If latched count=0, go directly to PASS.
  - If latched count>DEPTH, go to FAIL with code 3.
  - Otherwise go to RUN. start while in RUN is ignored.
- RUN, per edge with mem_write=1:
  - If data_adr==entry[match_cnt].addr and write_data==entry[match_cnt].data, this is a match: match_cnt++ and the watchdog clears. If match_cnt+1==count, go to PASS.
  - If there is no match and STRICT=1: go to FAIL, code 1; capture data_adr and write_data into fail_addr/fail_data.
  - If there is no match and STRICT=0: stray_cnt++ (saturating); the watchdog does not clear.
- RUN, watchdog: increments each cycle without a match. When it reaches TIMEOUT-1 and the current cycle has no match, go to FAIL, code 2. A match on the same edge takes priority over the timeout.
- Only one write is evaluated per cycle. Writes in IDLE/PASS/FAIL are ignored.
- PASS/FAIL are sticky until the next start or reset.
- Asynchronous reset mid-RUN aborts the check and returns to IDLE with the table cleared.

Test Plan:
- Load entry0=(252, 0x00001000), count=1, start; after 3 idle cycles, write 252/0x1000 -> next cycle done=1, pass=1, match_cnt=1, fail_code=0.
- Same setup, write 252/0x00000FFF -> done=1, pass=0, fail_code=1, fail_addr=252, fail_data=0xFFF.
- STRICT=0, DEPTH=4, entries (0x10,1),(0x14,2),(0x18,3),(0xFC,0x1000), count=4. Write (0x10,1), stray (0x40,7), then the remaining three in order -> pass=1, stray_cnt=1, match_cnt=4.
- TIMEOUT=16, count=1, no writes after start -> FAIL with fail_code=2 exactly 16 cycles after RUN entry, fail_addr=0.
- Matching write on the same edge as watchdog expiry -> pass=1, not fail. Count=0 -> pass next cycle. Count=5 with DEPTH=4 -> fail_code=3.
- Drop reset to 0 mid-RUN after 1 match -> outputs 0 immediately; after release, re-load, then start -> sequence checks from entry0.
